// File: rtl/vid_mem_responder.sv
// vid_mem_responder: memory model and responder on the video pixel-fetch bus.
// It answers read bursts by bidding for the bus and streaming RAM words.
// It accepts write bursts that preload the word-addressed frame buffer.
module vid_mem_responder #(
  parameter int unsigned ADDR_W  = 10,
  parameter logic [3:0]  INIT_ID = 4'h1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        selin,
  input  logic [2:0]  cmdin,
  input  logic [1:0]  lenin,
  input  logic [31:0] addrdatain,
  input  logic        ackin,
  output logic [1:0]  reqout,
  output logic [2:0]  cmdout,
  output logic [1:0]  lenout,
  output logic [31:0] addrdataout,
  output logic [3:0]  reqtar,
  output logic        busy
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  localparam logic [2:0] CMD_IDLE    = 3'b000;
  localparam logic [2:0] CMD_WR_DATA = 3'b001;
  localparam logic [2:0] CMD_RD_REQ  = 3'b010;
  localparam logic [2:0] CMD_RD_DATA = 3'b011;
  localparam logic [2:0] CMD_WR_REQ  = 3'b100;
  localparam logic [2:0] CMD_WR_RESP = 3'b101;

  localparam logic [ADDR_W-1:0] IDX_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_BID,
    S_RD_DATA,
    S_WR_RESP,
    S_WR_DATA
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_idx;
  logic [3:0]        r_cnt;
  logic [1:0]        r_len;
  logic [31:0]       r_mem [DEPTH];

  logic              w_req_rd;
  logic              w_req_wr;
  logic              w_wr_beat;
  logic              w_last;
  logic [3:0]        w_beats_m1;

  // Decode incoming commands and burst bookkeeping.
  always_comb begin
    w_req_rd   = selin && (cmdin == CMD_RD_REQ);
    w_req_wr   = selin && (cmdin == CMD_WR_REQ);
    w_wr_beat  = (r_state == S_WR_DATA) && selin && (cmdin == CMD_WR_DATA);
    w_last     = (r_cnt == 4'd0);
    w_beats_m1 = (4'd1 << lenin) - 4'd1;
  end

  // Frame-buffer RAM write port; no reset so contents survive reset.
  always_ff @(posedge clk) begin
    if (w_wr_beat) begin
      r_mem[r_idx] <= addrdatain;
    end
  end

  // Burst sequencer with registered bus outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_len       <= '0;
      reqout      <= '0;
      cmdout      <= '0;
      lenout      <= '0;
      addrdataout <= '0;
      reqtar      <= '0;
      busy        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req_rd) begin
            r_idx   <= addrdatain[ADDR_W+1:2];
            r_len   <= lenin;
            r_cnt   <= w_beats_m1;
            reqout  <= 2'b11;
            busy    <= 1'b1;
            r_state <= S_RD_BID;
          end else if (w_req_wr) begin
            r_idx   <= addrdatain[ADDR_W+1:2];
            r_len   <= lenin;
            r_cnt   <= w_beats_m1;
            cmdout  <= CMD_WR_RESP;
            busy    <= 1'b1;
            r_state <= S_WR_RESP;
          end
        end
        S_RD_BID: begin
          if (ackin) begin
            reqout      <= '0;
            cmdout      <= CMD_RD_DATA;
            addrdataout <= r_mem[r_idx];
            lenout      <= r_len;
            reqtar      <= INIT_ID;
            r_idx       <= r_idx + IDX_ONE;
            r_state     <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          // r_cnt counts beats still to follow the one currently on the bus.
          if (w_last) begin
            cmdout      <= '0;
            addrdataout <= '0;
            lenout      <= '0;
            reqtar      <= '0;
            busy        <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_cnt       <= r_cnt - 4'd1;
            addrdataout <= r_mem[r_idx];
            r_idx       <= r_idx + IDX_ONE;
          end
        end
        S_WR_RESP: begin
          cmdout  <= '0;
          r_state <= S_WR_DATA;
        end
        S_WR_DATA: begin
          if (w_wr_beat) begin
            r_idx <= r_idx + IDX_ONE;
            if (w_last) begin
              busy    <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_cnt <= r_cnt - 4'd1;
            end
          end else if (selin && (cmdin != CMD_IDLE)) begin
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vid_mem_responder.sv
// Testbench for vid_mem_responder: scripted and randomized bursts checked
// against a word-array model of the frame buffer and the bus timing rules.
module tb_vid_mem_responder;

  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned DEPTH   = 1 << ADDR_W;
  localparam logic [3:0]  INIT_ID = 4'h5;

  logic        clk;
  logic        reset_n;
  logic        selin;
  logic [2:0]  cmdin;
  logic [1:0]  lenin;
  logic [31:0] addrdatain;
  logic        ackin;
  logic [1:0]  reqout;
  logic [2:0]  cmdout;
  logic [1:0]  lenout;
  logic [31:0] addrdataout;
  logic [3:0]  reqtar;
  logic        busy;

  vid_mem_responder #(.ADDR_W(ADDR_W), .INIT_ID(INIT_ID)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .selin       (selin),
    .cmdin       (cmdin),
    .lenin       (lenin),
    .addrdatain  (addrdatain),
    .ackin       (ackin),
    .reqout      (reqout),
    .cmdout      (cmdout),
    .lenout      (lenout),
    .addrdataout (addrdataout),
    .reqtar      (reqtar),
    .busy        (busy)
  );

  logic [31:0] model_mem [DEPTH];
  logic [31:0] wbuf [8];
  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    total++;
    if (reqout !== 2'b00 || cmdout !== 3'b000 || lenout !== 2'b00 ||
        addrdataout !== 32'h0 || reqtar !== 4'h0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s idle: req=%0h cmd=%0h len=%0h data=%08h tar=%0h busy=%0b required all 0",
               tag, reqout, cmdout, lenout, addrdataout, reqtar, busy);
    end
  endtask

  // Write burst from wbuf; stalls between beats are random in [min_st,max_st].
  task automatic do_write(input logic [31:0] addr, input logic [1:0] len,
                          input int unsigned min_st, input int unsigned max_st,
                          input bit rd_in_resp, input string tag);
    int unsigned idx   = (addr >> 2) % DEPTH;
    int unsigned beats = 1 << len;
    selin = 1'b1; cmdin = 3'b100; lenin = len; addrdatain = addr;
    tick;
    total++;
    if (cmdout !== 3'b101 || busy !== 1'b1 || reqout !== 2'b00) begin
      bad++;
      $display("FAIL %s wr_resp: cmd=%0h busy=%0b req=%0h required cmd=5 busy=1 req=0",
               tag, cmdout, busy, reqout);
    end
    if (rd_in_resp) begin
      cmdin = 3'b010; addrdatain = 32'h100;
    end else begin
      cmdin = 3'b000; addrdatain = $urandom;
    end
    tick;
    total++;
    if (cmdout !== 3'b000 || busy !== 1'b1 || reqout !== 2'b00) begin
      bad++;
      $display("FAIL %s wr_data_entry: cmd=%0h busy=%0b req=%0h required cmd=0 busy=1 req=0",
               tag, cmdout, busy, reqout);
    end
    for (int k = 0; k < int'(beats); k++) begin
      int unsigned st = $urandom_range(max_st, min_st);
      for (int s = 0; s < int'(st); s++) begin
        if ($urandom_range(1, 0) == 1) begin
          selin = 1'b1; cmdin = 3'b000;
        end else begin
          selin = 1'b0; cmdin = 3'($urandom_range(5, 0));
        end
        addrdatain = $urandom;
        tick;
        total++;
        if (busy !== 1'b1 || reqout !== 2'b00 || cmdout !== 3'b000) begin
          bad++;
          $display("FAIL %s stall%0d: busy=%0b req=%0h cmd=%0h required busy=1 req=0 cmd=0",
                   tag, k, busy, reqout, cmdout);
        end
      end
      selin = 1'b1; cmdin = 3'b001; addrdatain = wbuf[k];
      tick;
      model_mem[(idx + k) % DEPTH] = wbuf[k];
      total++;
      if (busy !== (k != int'(beats) - 1) || reqout !== 2'b00 || cmdout !== 3'b000) begin
        bad++;
        $display("FAIL %s beat%0d: busy=%0b req=%0h cmd=%0h required busy=%0b req=0 cmd=0",
                 tag, k, busy, reqout, cmdout, (k != int'(beats) - 1));
      end
    end
    cmdin = 3'b000; addrdatain = '0;
  endtask

  // Read burst; nbid = cycles reqout must stay 11; rst_beat aborts via reset.
  task automatic do_read(input logic [31:0] addr, input logic [1:0] len,
                         input int unsigned nbid, input int rst_beat,
                         input string tag);
    int unsigned idx   = (addr >> 2) % DEPTH;
    int unsigned beats = 1 << len;
    selin = 1'b1; cmdin = 3'b010; lenin = len; addrdatain = addr;
    ackin = (nbid == 1);
    tick;
    for (int b = 0; b < int'(nbid); b++) begin
      // requests while busy must be dropped
      cmdin = ($urandom_range(1, 0) == 1) ? 3'b100 : 3'b000;
      addrdatain = $urandom;
      total++;
      if (reqout !== 2'b11 || busy !== 1'b1 || cmdout !== 3'b000) begin
        bad++;
        $display("FAIL %s bid%0d: req=%0h busy=%0b cmd=%0h required req=3 busy=1 cmd=0",
                 tag, b, reqout, busy, cmdout);
      end
      if (b == int'(nbid) - 1) ackin = 1'b1;
      tick;
    end
    for (int k = 0; k < int'(beats); k++) begin
      logic [31:0] exp_d = model_mem[(idx + k) % DEPTH];
      ackin = $urandom_range(1, 0);
      cmdin = ($urandom_range(1, 0) == 1) ? 3'b010 : 3'b000;
      total++;
      if (cmdout !== 3'b011 || addrdataout !== exp_d || lenout !== len ||
          reqtar !== INIT_ID || reqout !== 2'b00 || busy !== 1'b1) begin
        bad++;
        $display("FAIL %s beat%0d: cmd=%0h data=%08h len=%0h tar=%0h req=%0h busy=%0b required cmd=3 data=%08h len=%0h tar=%0h req=0 busy=1",
                 tag, k, cmdout, addrdataout, lenout, reqtar, reqout, busy,
                 exp_d, len, INIT_ID);
      end
      if (k == rst_beat) begin
        reset_n = 1'b0;
        #1;
        check_idle_outputs({tag, "_rst"});
        reset_n = 1'b1;
        cmdin = 3'b000; ackin = 1'b0;
        return;
      end
      tick;
    end
    check_idle_outputs(tag);
    cmdin = 3'b000; ackin = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; selin = 1'b0; cmdin = '0; lenin = '0; addrdatain = '0; ackin = 1'b0;
    repeat (2) tick;
    check_idle_outputs("reset");
    reset_n = 1'b1;
    tick;
    check_idle_outputs("post_reset");
  endtask

  task automatic test_burst;
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + i;
    do_write(32'h100, 2'd2, 0, 0, 1'b0, "burst_wr");
    do_read(32'h100, 2'd2, 1, -1, "burst_rd");
  endtask

  task automatic test_ack_delay;
    do_read(32'h100, 2'd0, 3, -1, "ack_delay");
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 8; i++) wbuf[i] = i + 1;
    do_write(32'hFF8, 2'd3, 0, 0, 1'b0, "wrap_wr");
    do_read(32'hFF8, 2'd3, 2, -1, "wrap_rd");
  endtask

  task automatic test_stall_write;
    for (int i = 0; i < 4; i++) wbuf[i] = $urandom;
    do_write(32'h200, 2'd2, 1, 3, 1'b0, "stall_wr");
    do_read(32'h200, 2'd2, 1, -1, "stall_rd");
  endtask

  task automatic test_read_during_write;
    for (int i = 0; i < 4; i++) wbuf[i] = $urandom;
    do_write(32'h300, 2'd2, 0, 1, 1'b1, "rdw_wr");
    tick;
    check_idle_outputs("rdw_no_bid");
    do_read(32'h300, 2'd2, 1, -1, "rdw_rd");
  endtask

  task automatic test_abort;
    logic [31:0] first = $urandom;
    selin = 1'b1; cmdin = 3'b100; lenin = 2'd2; addrdatain = 32'h380;
    tick;
    cmdin = 3'b000;
    tick;
    cmdin = 3'b001; addrdatain = first;
    tick;
    model_mem[32'h380 >> 2] = first;
    cmdin = 3'b011; addrdatain = $urandom;
    tick;
    cmdin = 3'b000;
    check_idle_outputs("abort");
    do_read(32'h380, 2'd0, 1, -1, "abort_rd");
  endtask

  task automatic test_reset_midburst;
    do_read(32'h100, 2'd2, 1, 1, "rst_mid");
    do_read(32'h100, 2'd2, 2, -1, "rst_after");
  endtask

  task automatic test_random;
    for (int it = 0; it < 24; it++) begin
      logic [31:0] a = $urandom;
      logic [1:0]  l = 2'($urandom_range(3, 0));
      for (int i = 0; i < 8; i++) wbuf[i] = $urandom;
      do_write(a, l, 0, 2, 1'b0, "rand_wr");
      do_read(a, l, $urandom_range(4, 1), -1, "rand_rd");
    end
  endtask

  initial begin
    test_reset;
    test_burst;
    test_ack_delay;
    test_wrap;
    test_stall_write;
    test_read_during_write;
    test_abort;
    test_reset_midburst;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vid_mem_responder.md
# vid_mem_responder

Bus-target memory model and responder for the video pixel-fetch bus. It answers the read bursts issued by the video controller's fetch engine and accepts write bursts that preload the frame buffer. It sits on the far side of the same cmd/len/addrdata bus as the controller, in place of the testbench-driven responder. It owns a word-addressed frame-buffer RAM, bids for the bus to return read data, and sequences burst beats.

## Interface
- `ADDR_W`, default 10: log2 of the RAM depth in 32-bit words.
- `INIT_ID`, default 4'h1: value driven on `reqtar` while returning read data.
- `clk` in 1: single clock; all logic is on its rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `selin` in 1: this target is selected; commands are ignored when it is 0.
- `cmdin` in 3: 000 idle, 001 write data, 010 read request, 011 read data, 100 write request, 101 write response.
- `lenin` in 2: burst length code; beats = 1 << `lenin` (1/2/4/8).
- `addrdatain` in 32: byte address in request cycles; write data in data cycles.
- `ackin` in 1: bus grant for this block's bid.
- `reqout` out 2: 2'b11 while bidding, else 2'b00.
- `cmdout` out 3: 011 on read-data beats, 101 on the write-response cycle, else 000.
- `lenout` out 2: captured `lenin` during read-data beats, else 0.
- `addrdataout` out 32: read data during beats, else 0.
- `reqtar` out 4: `INIT_ID` during read-data beats, else 0.
- `busy` out 1: high in every state except IDLE.

## Operation
- RAM: 2^`ADDR_W` x 32. Word index = `addr[ADDR_W+1:2]`; `addr[1:0]` is ignored. Contents are not cleared by reset and persist across resets.
- Burst addressing: the index increments by 1 per beat and wraps modulo 2^`ADDR_W`.
- The beat counter is 4 bits and loads beats-1. The last beat is the one where the counter equals 0.
- States:
  - IDLE:
    - `selin`&&`cmdin`==010 → capture addr and len, go to RD_BID.
    - `selin`&&`cmdin`==100 → capture addr and len, go to WR_RESP.
    - Anything else → stay in IDLE.
  - RD_BID: `reqout`=11. Stay until `ackin` is sampled 1, then go to RD_DATA.
  - RD_DATA: one beat per cycle with no gaps: `cmdout`=011, `addrdataout`=RAM[idx], `lenout`, `reqtar`. After the last beat, go to IDLE.
  - WR_RESP: `cmdout`=101 for exactly one cycle, then go to WR_DATA.
  - WR_DATA:
    - `selin`&&`cmdin`==001 → write `addrdatain` to RAM[idx], advance idx, decrement counter; after the last beat, go to IDLE.
    - `cmdin`==000 or `selin`=0 → stall, no write.
    - Any other cmd with `selin` → abort to IDLE; already-written beats remain.
- Requests arriving while `busy` is high are dropped, not queued.
- `ackin` is ignored outside RD_BID.
- Reads in RD_DATA return RAM contents as of the start of the burst. No write can overlap a read burst.

## Timing
- All outputs are registered.
- Reset values: `reqout`=0, `cmdout`=0, `lenout`=0, `addrdataout`=0, `reqtar`=0, `busy`=0, state IDLE.
- Asserting `reset_n` low mid-burst forces every output to 0 and the state to IDLE. The RAM is unchanged.
- Read, with the request sampled at edge t:
  - `reqout`=11 and `busy`=1 from t+1.
  - `ackin` sampled high at edge g → beat 0 drives from g+1 and `reqout` drops to 00 at g+1.
  - Beat k drives in cycle g+1+k.
  - All outputs return to 0 in the cycle after the last beat.
- Minimum read latency (request edge to first data) is 2 cycles, when `ackin` is already high at t+1.
- Write, with the request sampled at edge t:
  - `cmdout`=101 during cycle t+1.
  - Data beats are accepted from edge t+2 onward.
  - RAM is updated at the sampling edge of each beat.
- Back-to-back: a new request is accepted on the first edge at which the state is IDLE, i.e. the cycle after the last beat.

## Test plan
- Write burst `lenin`=2 to 0x100 with data 0xA0..0xA3; read burst `lenin`=2 from 0x100 with `ackin` held high → `cmdout`=011 for 4 consecutive cycles returning 0xA0,0xA1,0xA2,0xA3, `lenout`=2, `reqtar`=`INIT_ID`, first beat 2 cycles after the request.
- Read `lenin`=0 with `ackin` delayed 3 cycles → `reqout`=11 for exactly 3 cycles, then a single beat, then all outputs 0.
- Write `lenin`=3 starting at word 2^`ADDR_W`-2 (0xFF8 for `ADDR_W`=10) with values 1..8; read back from 0xFF8 → 1..8, with beats 3..8 coming from words 0..5 (wrap).
- Write burst of 4 with 000 stall cycles between every beat → exactly 4 RAM writes, `busy` high throughout, IDLE after the 4th data beat; a read-back matches.
- Issue a read request during a write burst → request ignored and no bid; the write completes normally.
- Pulse `reset_n` low during beat 1 of a 4-beat read → outputs 0 immediately, `busy`=0; a subsequent read returns the unchanged RAM contents.
